// File: rtl/aibcr3pnr_bsr_pkg.sv
// Shared types, cell layout and helpers for the AIB boundary-scan / redundancy chain.
package aibcr3pnr_bsr_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck} red_state_e;

  localparam int unsigned CELL  = 4;
  localparam int unsigned ODAT0 = 3;
  localparam int unsigned ITXEN = 2;
  localparam int unsigned IDAT1 = 1;
  localparam int unsigned IDAT0 = 0;

  // True when, within the low n bits, no set bit is followed by a clear bit above it.
  function automatic logic is_thermo(input logic [31:0] v, input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (i < n && v[i-1] && !v[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/aibcr3pnr_bsr_red_chain_if.sv
// Adapter/AIB data, scan control and repair-loader signals of the redundancy chain.
interface aibcr3pnr_bsr_red_chain_if #(
  parameter int unsigned NCH = 8
);
  logic [NCH-1:0] idat0_adap;
  logic [NCH-1:0] idat1_adap;
  logic [NCH-1:0] itxen_adap;
  logic [NCH-1:0] odat0_adap;
  logic [NCH:0]   idat0_aib;
  logic [NCH:0]   idat1_aib;
  logic [NCH:0]   itxen_aib;
  logic [NCH:0]   odat0_aib;
  logic           jtag_tx_scan_in;
  logic           jtag_rx_scan_out;
  logic           jtag_tx_scanen_in;
  logic           jtag_capture_en;
  logic           jtag_update_en;
  logic           jtag_mode_in;
  logic           jtag_intest;
  logic           red_load;
  logic           red_ser_in;
  logic           red_ser_vld;
  logic           red_busy;
  logic           red_done;
  logic           red_err;
  logic [NCH-1:0] red_shift_en;

  modport slave (
    input  idat0_adap, idat1_adap, itxen_adap, odat0_aib,
    input  jtag_tx_scan_in, jtag_tx_scanen_in, jtag_capture_en, jtag_update_en,
    input  jtag_mode_in, jtag_intest, red_load, red_ser_in, red_ser_vld,
    output odat0_adap, idat0_aib, idat1_aib, itxen_aib, jtag_rx_scan_out,
    output red_busy, red_done, red_err, red_shift_en
  );

  modport master (
    output idat0_adap, idat1_adap, itxen_adap, odat0_aib,
    output jtag_tx_scan_in, jtag_tx_scanen_in, jtag_capture_en, jtag_update_en,
    output jtag_mode_in, jtag_intest, red_load, red_ser_in, red_ser_vld,
    input  odat0_adap, idat0_aib, idat1_aib, itxen_aib, jtag_rx_scan_out,
    input  red_busy, red_done, red_err, red_shift_en
  );

endinterface

// File: rtl/aibcr3pnr_red_fuse_ld.sv
// Serial repair loader: collects the redundancy vector, validates it, then applies it.
// AIBCR3PNR_RED_FUSE_PARITY_EN adds a trailing even-parity bit to the serial load.
module aibcr3pnr_red_fuse_ld
  import aibcr3pnr_bsr_pkg::*;
#(
  parameter int unsigned NCH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           ser_i,
  input  logic           ser_vld_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [NCH-1:0] sh_o
);

`ifdef AIBCR3PNR_RED_FUSE_PARITY_EN
  localparam int unsigned LdBits = NCH + 1;
`else
  localparam int unsigned LdBits = NCH;
`endif
  localparam int unsigned KW = $clog2(LdBits + 1);

  red_state_e        state_q, state_d;
  logic [LdBits-1:0] stage_q, stage_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NCH-1:0]    sh_q, sh_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vec_ok;

  always_comb begin
    vec_ok = is_thermo(32'(stage_q[NCH-1:0]), NCH);
`ifdef AIBCR3PNR_RED_FUSE_PARITY_EN
    // Data plus parity bit must hold an even number of ones.
    vec_ok = vec_ok & ~(^stage_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    sh_d    = sh_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d = StLoad;
          stage_d = '0;
          k_d     = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (ser_vld_i) begin
          stage_d[k_q] = ser_i;
          k_d          = k_q + KW'(1);
          if (k_q == KW'(LdBits - 1)) state_d = StCheck;
        end
      end
      StCheck: begin
        done_d  = 1'b1;
        sh_d    = vec_ok ? stage_q[NCH-1:0] : '0;
        err_d   = ~vec_ok;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign err_o  = err_q;
  assign sh_o   = sh_q;

endmodule

// File: rtl/aibcr3pnr_bsr_red_chain.sv
// NCH-channel AIB boundary-scan chain with one spare physical channel and serial repair.
// AIBCR3PNR_RED_FUSE_PARITY_EN (see aibcr3pnr_red_fuse_ld) enables the repair parity bit.
module aibcr3pnr_bsr_red_chain
  import aibcr3pnr_bsr_pkg::*;
#(
  parameter int unsigned NCH = 8
) (
  input logic                     jtag_clkdr_in,
  input logic                     jtag_rst,
  aibcr3pnr_bsr_red_chain_if.slave bus
);

  localparam int unsigned NPH = NCH + 1;
  localparam int unsigned L   = CELL * NPH;

  logic [NCH-1:0] sh;
  logic [NPH-1:0] sh_ext, sh_prev;
  logic [NPH-1:0] tx_idat0, tx_idat1, tx_itxen;
  logic [NPH-1:0] upd_idat0, upd_idat1, upd_itxen, upd_odat0;
  logic [NCH-1:0] rx_func, rx_test;
  logic [L-1:0]   ch_q, ch_d, cap, upd_q;

  aibcr3pnr_red_fuse_ld #(
    .NCH(NCH)
  ) u_fuse_ld (
    .clk_i    (jtag_clkdr_in),
    .rst_i    (jtag_rst),
    .load_i   (bus.red_load),
    .ser_i    (bus.red_ser_in),
    .ser_vld_i(bus.red_ser_vld),
    .busy_o   (bus.red_busy),
    .done_o   (bus.red_done),
    .err_o    (bus.red_err),
    .sh_o     (sh)
  );

  assign bus.red_shift_en = sh;

  // Spare slot never owns a channel; sh_prev[p] tells whether channel p-1 moved up onto p.
  assign sh_ext  = {1'b1, sh};
  assign sh_prev = {sh, 1'b0};

  assign tx_idat0 = (~sh_ext & {1'b0, bus.idat0_adap}) | (sh_ext & sh_prev & {bus.idat0_adap, 1'b0});
  assign tx_idat1 = (~sh_ext & {1'b0, bus.idat1_adap}) | (sh_ext & sh_prev & {bus.idat1_adap, 1'b0});
  assign tx_itxen = (~sh_ext & {1'b0, bus.itxen_adap}) | (sh_ext & sh_prev & {bus.itxen_adap, 1'b0});

  always_comb begin
    cap       = '0;
    upd_idat0 = '0;
    upd_idat1 = '0;
    upd_itxen = '0;
    upd_odat0 = '0;
    for (int unsigned p = 0; p < NPH; p++) begin
      cap[CELL*p + IDAT0] = tx_idat0[p];
      cap[CELL*p + IDAT1] = tx_idat1[p];
      cap[CELL*p + ITXEN] = tx_itxen[p];
      cap[CELL*p + ODAT0] = bus.odat0_aib[p];
      upd_idat0[p]        = upd_q[CELL*p + IDAT0];
      upd_idat1[p]        = upd_q[CELL*p + IDAT1];
      upd_itxen[p]        = upd_q[CELL*p + ITXEN];
      upd_odat0[p]        = upd_q[CELL*p + ODAT0];
    end
  end

  assign rx_func = (~sh & bus.odat0_aib[NCH-1:0]) | (sh & bus.odat0_aib[NCH:1]);
  assign rx_test = (~sh & upd_odat0[NCH-1:0]) | (sh & upd_odat0[NCH:1]);

  assign bus.odat0_adap = bus.jtag_intest  ? rx_test   : rx_func;
  assign bus.idat0_aib  = bus.jtag_mode_in ? upd_idat0 : tx_idat0;
  assign bus.idat1_aib  = bus.jtag_mode_in ? upd_idat1 : tx_idat1;
  assign bus.itxen_aib  = bus.jtag_mode_in ? upd_itxen : tx_itxen;

  always_comb begin
    ch_d = ch_q;
    if (bus.jtag_tx_scanen_in) begin
      ch_d = {bus.jtag_tx_scan_in, ch_q[L-1:1]};
    end else if (bus.jtag_capture_en) begin
      ch_d = cap;
    end
  end

  always_ff @(posedge jtag_clkdr_in) begin
    if (jtag_rst) begin
      ch_q  <= '0;
      upd_q <= '0;
    end else begin
      ch_q <= ch_d;
      if (bus.jtag_update_en && !bus.jtag_tx_scanen_in) upd_q <= ch_q;
    end
  end

  assign bus.jtag_rx_scan_out = ch_q[0];

endmodule

// File: tb/tb_aibcr3pnr_bsr_red_chain.sv
// Scoreboard bench: stimulus queues expectations from a channel-mapping model, a monitor checks.
module tb_aibcr3pnr_bsr_red_chain;
  import aibcr3pnr_bsr_pkg::*;

  localparam int unsigned NCH = 8;
  localparam int unsigned L   = CELL * (NCH + 1);
`ifdef AIBCR3PNR_RED_FUSE_PARITY_EN
  localparam int unsigned LD_BITS = NCH + 1;
  localparam bit          PAR_EN  = 1'b1;
`else
  localparam int unsigned LD_BITS = NCH;
  localparam bit          PAR_EN  = 1'b0;
`endif

  localparam int ID_IDAT0 = 0, ID_IDAT1 = 1, ID_ITXEN = 2, ID_ODAT0 = 3, ID_BUSY = 4;
  localparam int ID_DONE = 5, ID_ERR = 6, ID_SH = 7, ID_SOUT = 8;

  typedef struct {int id; logic [63:0] exp;} pin_t;
  typedef struct {logic err; logic [NCH-1:0] sh; int cyc;} rep_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  pin_t pin_q[$];
  rep_t rep_q[$];
  logic scan_q[$];
  logic [NCH-1:0] model_sh;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aibcr3pnr_bsr_red_chain_if #(.NCH(NCH)) bus ();
  aibcr3pnr_bsr_red_chain #(.NCH(NCH)) dut (
    .jtag_clkdr_in(clk),
    .jtag_rst     (rst),
    .bus          (bus)
  );

  // Reference: functional channel i lives on physical i+sh[i].
  function automatic logic [NCH:0] model_tx(input logic [NCH-1:0] a, input logic [NCH-1:0] s);
    logic [NCH:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i + int'(s[i])] = a[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] model_rx(input logic [NCH:0] o, input logic [NCH-1:0] s);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = o[i + int'(s[i])];
    return r;
  endfunction

  // A legal vector is exactly the top popcount bits set.
  function automatic logic model_valid(input logic [NCH-1:0] v);
    logic [NCH-1:0] m;
    m = '1;
    m = m << (NCH - $countones(v));
    return v == m;
  endfunction

  function automatic string id_name(input int id);
    case (id)
      ID_IDAT0: return "idat0_aib";
      ID_IDAT1: return "idat1_aib";
      ID_ITXEN: return "itxen_aib";
      ID_ODAT0: return "odat0_adap";
      ID_BUSY:  return "red_busy";
      ID_DONE:  return "red_done";
      ID_ERR:   return "red_err";
      ID_SH:    return "red_shift_en";
      default:  return "scan_out";
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pin(input int id, input logic [63:0] v);
    pin_t it;
    it.id  = id;
    it.exp = v;
    pin_q.push_back(it);
  endtask

  task automatic do_load(input logic [NCH-1:0] v, input bit bad_par, input bit gaps,
                         input bit poke);
    logic [LD_BITS-1:0] bits;
    logic               exp_err;
    int                 last_c;
    rep_t               r;
`ifdef AIBCR3PNR_RED_FUSE_PARITY_EN
    bits = {(^v) ^ bad_par, v};
`else
    bits = v;
`endif
    exp_err = !model_valid(v) || (PAR_EN && bad_par);
    last_c  = cyc;
    bus.red_load = 1'b1;
    step();
    bus.red_load = 1'b0;
    expect_pin(ID_BUSY, 64'd1);
    expect_pin(ID_DONE, 64'd0);
    expect_pin(ID_ERR, 64'd0);
    for (int j = 0; j < int'(LD_BITS); j++) begin
      if (gaps) repeat ($urandom_range(2)) step();
      bus.red_ser_in  = bits[j];
      bus.red_ser_vld = 1'b1;
      if (poke && j == 2) bus.red_load = 1'b1;
      last_c = cyc;
      step();
      bus.red_ser_vld = 1'b0;
      bus.red_ser_in  = 1'b0;
      bus.red_load    = 1'b0;
      if (j == 0) expect_pin(ID_SH, 64'(model_sh));
    end
    r.err = exp_err;
    r.sh  = exp_err ? '0 : v;
    r.cyc = last_c + 2;
    rep_q.push_back(r);
    model_sh = r.sh;
    repeat (4) begin
      if (rep_q.size() == 0) break;
      step();
    end
    if (rep_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL repair_timeout got=no_done want=done_by_cycle_%0d", r.cyc);
      rep_q.delete();
    end
  endtask

  task automatic check_datapath(input logic [NCH-1:0] a0, input logic [NCH-1:0] a1,
                                input logic [NCH-1:0] te, input logic [NCH:0] o);
    bus.idat0_adap = a0;
    bus.idat1_adap = a1;
    bus.itxen_adap = te;
    bus.odat0_aib  = o;
    expect_pin(ID_IDAT0, 64'(model_tx(a0, model_sh)));
    expect_pin(ID_IDAT1, 64'(model_tx(a1, model_sh)));
    expect_pin(ID_ITXEN, 64'(model_tx(te, model_sh)));
    expect_pin(ID_ODAT0, 64'(model_rx(o, model_sh)));
    step();
  endtask

  // Monitor: compares queued pin checks, scan-out bits and repair completions.
  initial begin
    pin_t        it;
    rep_t        r;
    logic [63:0] act;
    logic        exp_b;
    logic        done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (pin_q.size() > 0) begin
        it = pin_q.pop_front();
        case (it.id)
          ID_IDAT0: act = 64'(bus.idat0_aib);
          ID_IDAT1: act = 64'(bus.idat1_aib);
          ID_ITXEN: act = 64'(bus.itxen_aib);
          ID_ODAT0: act = 64'(bus.odat0_adap);
          ID_BUSY:  act = 64'(bus.red_busy);
          ID_DONE:  act = 64'(bus.red_done);
          ID_ERR:   act = 64'(bus.red_err);
          ID_SH:    act = 64'(bus.red_shift_en);
          default:  act = 64'(bus.jtag_rx_scan_out);
        endcase
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s cycle=%0d got=%0h want=%0h", id_name(it.id), cyc, act, it.exp);
        end
      end
      if (bus.jtag_tx_scanen_in === 1'b1 && scan_q.size() > 0) begin
        exp_b = scan_q.pop_front();
        checks++;
        if (bus.jtag_rx_scan_out !== exp_b) begin
          failures++;
          $display("FAIL scan_stream cycle=%0d got=%0b want=%0b", cyc, bus.jtag_rx_scan_out,
                   exp_b);
        end
      end
      if (bus.red_done === 1'b1 && done_prev !== 1'b1) begin
        checks++;
        if (rep_q.size() == 0) begin
          failures++;
          $display("FAIL repair_unexpected_done cycle=%0d got=done want=idle", cyc);
        end else begin
          r = rep_q.pop_front();
          if ({bus.red_err, bus.red_shift_en} !== {r.err, r.sh} || cyc != r.cyc) begin
            failures++;
            $display("FAIL repair got=err%0b/sh%0h@%0d want=err%0b/sh%0h@%0d", bus.red_err,
                     bus.red_shift_en, cyc, r.err, r.sh, r.cyc);
          end
        end
      end
      done_prev = bus.red_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] v;
    logic [L-1:0]   stream;
    logic [NCH:0]   t0, t1, te;
    rst                   = 1'b1;
    model_sh              = '0;
    bus.idat0_adap        = '0;
    bus.idat1_adap        = '0;
    bus.itxen_adap        = '0;
    bus.odat0_aib         = '0;
    bus.jtag_tx_scan_in   = 1'b0;
    bus.jtag_tx_scanen_in = 1'b0;
    bus.jtag_capture_en   = 1'b0;
    bus.jtag_update_en    = 1'b0;
    bus.jtag_mode_in      = 1'b0;
    bus.jtag_intest       = 1'b0;
    bus.red_load          = 1'b0;
    bus.red_ser_in        = 1'b0;
    bus.red_ser_vld       = 1'b0;
    repeat (2) step();
    foreach (pin_q[i]) pin_q.delete();
    expect_pin(ID_BUSY, 64'd0);
    expect_pin(ID_DONE, 64'd0);
    expect_pin(ID_ERR, 64'd0);
    expect_pin(ID_SH, 64'd0);
    expect_pin(ID_SOUT, 64'd0);
    step();
    rst = 1'b0;

    // Directed loads and mappings.
    do_load(8'h00, 1'b0, 1'b0, 1'b0);
    bus.idat0_adap = 8'hA5;
    expect_pin(ID_IDAT0, 64'h0A5);
    step();
    do_load(8'hF0, 1'b0, 1'b0, 1'b0);
    bus.idat0_adap = 8'h98;
    bus.odat0_aib  = 9'h100;
    expect_pin(ID_IDAT0, 64'h128);
    expect_pin(ID_ODAT0, 64'h80);
    step();
    do_load(8'h50, 1'b0, 1'b0, 1'b0);

    // Capture with sh=0, then shift the whole chain out.
    bus.itxen_adap      = 8'hFF;
    bus.idat0_adap      = NCH'($urandom);
    bus.idat1_adap      = NCH'($urandom);
    bus.odat0_aib       = (NCH + 1)'($urandom);
    bus.jtag_capture_en = 1'b1;
    t0 = model_tx(bus.idat0_adap, model_sh);
    t1 = model_tx(bus.idat1_adap, model_sh);
    te = model_tx(bus.itxen_adap, model_sh);
    for (int p = 0; p <= int'(NCH); p++) begin
      stream[CELL*p + IDAT0] = t0[p];
      stream[CELL*p + IDAT1] = t1[p];
      stream[CELL*p + ITXEN] = te[p];
      stream[CELL*p + ODAT0] = bus.odat0_aib[p];
    end
    step();
    bus.jtag_capture_en = 1'b0;
    for (int b = 0; b < int'(L); b++) scan_q.push_back(stream[b]);
    bus.jtag_tx_scanen_in = 1'b1;
    repeat (L) step();
    bus.jtag_tx_scanen_in = 1'b0;

    // Shift in ones (capture on the first shift cycle must lose), then update.
    bus.odat0_aib         = '0;
    bus.jtag_tx_scan_in   = 1'b1;
    bus.jtag_tx_scanen_in = 1'b1;
    bus.jtag_capture_en   = 1'b1;
    step();
    bus.jtag_capture_en = 1'b0;
    repeat (L - 1) step();
    bus.jtag_update_en = 1'b1;
    step();
    bus.jtag_tx_scanen_in = 1'b0;
    bus.jtag_update_en    = 1'b0;
    bus.jtag_mode_in      = 1'b1;
    expect_pin(ID_IDAT0, 64'h0);
    expect_pin(ID_ITXEN, 64'h0);
    step();
    bus.jtag_update_en = 1'b1;
    step();
    bus.jtag_update_en = 1'b0;
    expect_pin(ID_IDAT0, 64'h1FF);
    expect_pin(ID_IDAT1, 64'h1FF);
    expect_pin(ID_ITXEN, 64'h1FF);
    bus.jtag_intest = 1'b1;
    expect_pin(ID_ODAT0, 64'hFF);
    step();
    bus.jtag_mode_in    = 1'b0;
    bus.jtag_intest     = 1'b0;
    bus.jtag_tx_scan_in = 1'b0;

    // Randomized repair loads followed by datapath checks.
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(1) == 1) begin
        v = '1;
        v = v << $urandom_range(NCH);
      end else begin
        v = NCH'($urandom);
      end
      do_load(v, 1'b0, $urandom_range(1) == 1, n == 3);
      check_datapath(NCH'($urandom), NCH'($urandom), NCH'($urandom), (NCH + 1)'($urandom));
    end

`ifdef AIBCR3PNR_RED_FUSE_PARITY_EN
    do_load(8'hF0, 1'b1, 1'b0, 1'b0);
`endif

    // Reset in the middle of LOAD after four bits.
    do_load(8'hC0, 1'b0, 1'b0, 1'b0);
    bus.red_load = 1'b1;
    step();
    bus.red_load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.red_ser_in  = 1'b1;
      bus.red_ser_vld = 1'b1;
      step();
    end
    bus.red_ser_vld = 1'b0;
    rst             = 1'b1;
    step();
    rst      = 1'b0;
    model_sh = '0;
    expect_pin(ID_BUSY, 64'd0);
    expect_pin(ID_SH, 64'd0);
    expect_pin(ID_DONE, 64'd0);
    step();
    check_datapath(NCH'($urandom), NCH'($urandom), NCH'($urandom), (NCH + 1)'($urandom));

    repeat (3) step();
    if (rep_q.size() != 0 || scan_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover got=%0d/%0d want=0/0", rep_q.size(), scan_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aibcr3pnr_bsr_red_chain.md
# aibcr3pnr_bsr_red_chain

Parametrised successor to the single-channel AIB boundary-scan/redundancy wrapper. It covers NCH functional channels plus one spare physical channel, with a full IEEE-1149-style scan cell per physical channel. A serial repair loader, driven by a small FSM, builds and validates the redundancy shift vector. It sits between the HSSI adapter and the AIB IO column in place of per-channel wrappers.

## Interface
- NCH, 8, functional channels; physical channels = NCH+1 (index NCH is the spare)
- CELL, 4, scan bits per physical channel (fixed: odat0, itxen, idat1, idat0)
- jtag_clkdr_in  in  1  single clock: functional registers, scan chain and repair FSM
- jtag_rst  in  1  reset, synchronous, active-high
- idat0_adap, idat1_adap, itxen_adap  in  NCH  TX from adapter (functional index)
- odat0_adap  out  NCH  RX to adapter (functional index)
- idat0_aib, idat1_aib, itxen_aib  out  NCH+1  TX to AIB (physical index)
- odat0_aib  in  NCH+1  RX from AIB (physical index)
- jtag_tx_scan_in  in  1  serial scan in
- jtag_rx_scan_out  out  1  serial scan out
- jtag_tx_scanen_in  in  1  shift DR
- jtag_capture_en  in  1  capture DR
- jtag_update_en  in  1  update DR
- jtag_mode_in  in  1  update regs drive AIB TX
- jtag_intest  in  1  update regs drive adapter RX
- red_load  in  1  start repair load
- red_ser_in, red_ser_vld  in  1  serial repair bit and qualifier
- red_busy, red_done, red_err  out  1  loader status
- red_shift_en  out  NCH  applied redundancy vector

## Operation
- Redundancy, combinational from the applied vector `sh`:
  - Functional ch i maps to physical i when sh[i]=0, else physical i+1.
  - Physical p TX = adapter ch p if p<NCH and !sh[p]; else ch p-1 if p>0 and sh[p-1]; else 0.
  - odat0_adap[i] = odat0_aib[i + sh[i]].
- `sh` must be a thermometer code (once a bit is 1, all higher bits are 1). Only validated vectors are applied.
- Scan chain `ch` has L=CELL*(NCH+1) bits. Physical p occupies bits [4p+3:4p] = {odat0, itxen, idat1, idat0}. jtag_rx_scan_out = ch[0].
- Per-cycle chain priority is reset > shift > capture > hold:
  - shift: ch <= {jtag_tx_scan_in, ch[L-1:1]}
  - capture: TX bits take the post-redundancy TX values; odat0 bits take odat0_aib.
- Update register `upd` (L bits): upd <= ch when jtag_update_en && !jtag_tx_scanen_in.
- jtag_mode_in=1: AIB TX pins take upd fields, bypassing the redundancy mux.
- jtag_intest=1: odat0_adap[i] takes the upd odat0 bit of physical i+sh[i]. This overrides functional RX only.
- Repair FSM:
  - IDLE: red_load -> LOAD. Clears the stage register, bit counter k and red_done/red_err.
  - LOAD: each red_ser_vld cycle writes stage[k] <= red_ser_in, k++. After the last bit -> CHECK.
  - CHECK (1 cycle): valid -> sh <= stage, red_done=1. Invalid -> sh <= 0, red_err=1, red_done=1. Then -> IDLE.
- red_busy = (state != IDLE).
- red_load is ignored while busy. red_load from IDLE after completion restarts the load; the old `sh` stays applied until the next CHECK.

## Timing
- Reset values: ch=0, upd=0, sh=0, stage=0, k=0, state=IDLE, red_busy/red_done/red_err=0, jtag_rx_scan_out=0.
- Scan: one bit per cycle. Bit shifted in at cycle t appears at scan_out at t+L.
- Capture, update and status outputs: 1-cycle register latency. Pin muxes are combinational from registered state.
- Repair: red_load at cycle t gives red_busy from t+1. With no vld gaps, the NCH-bit load ends at t+NCH, CHECK runs at t+NCH+1, and `sh` and red_done are visible at t+NCH+2.
- Reset mid-load: FSM returns to IDLE and sh=0.
- Capture and shift asserted together: shift wins.
- Update and shift asserted together: update is suppressed.

## Configuration
- AIBCR3PNR_RED_FUSE_PARITY_EN defined: LOAD consumes NCH+1 bits; the last bit is even parity over stage. A parity mismatch in CHECK is treated like a non-thermometer vector (red_err=1, sh=0).
- Undefined: NCH bits, no parity check, one cycle shorter.

## Structure
- Package aibcr3pnr_bsr_pkg: repair FSM state enum; cell bit-offset constants (ODAT0=3, ITXEN=2, IDAT1=1, IDAT0=0); function is_thermo().
- Sub-module aibcr3pnr_red_fuse_ld: repair FSM plus stage register. The top holds the muxes, the chain and `upd`.

## Test plan
- Reset then NCH=8 load of 0x00: red_done=1, red_err=0, sh=0. idat0_adap=0xA5 appears on idat0_aib as 9'h0A5.
- Load of 0xF0 (bits 4..7 set): ch3->phys3, ch4->phys5, ch7->phys8. odat0_aib=9'h100 gives odat0_adap=8'h80.
- Load of 0x50 (non-thermometer): red_err=1, sh=0, red_done at t+10.
- Capture with itxen_adap=0xFF, sh=0, then shift L=36 cycles: 36-bit stream matches the cell layout, with physical 8 itxen=0.
- Shift in 36 ones, update, jtag_mode_in=1: all itxen_aib/idat*_aib = 9'h1FF. Assert jtag_intest: odat0_adap=0xFF.
- jtag_rst asserted mid-LOAD at k=4: state IDLE, red_busy=0, sh=0 the next cycle. With parity enabled, a bad parity bit gives red_err=1.
